// File: rtl/clken_nco_gen_pkg.sv
// Shared constants and helpers for the NCO clock-enable generator.
// Optional feature macro: CLKEN_NCO_SQUARE_EN (adds per-channel sq_out).
package clken_nco_pkg;

  localparam int          ACC_W_DEF = 24;
  localparam longint      REFCLK_HZ = 50_000_000;

  localparam logic [23:0] INC_UART  = 24'd1237029;
  localparam logic [23:0] INC_VDP   = 24'd3603161;

  // Rounded increment producing hz from REFCLK_HZ with an acc_w-bit accumulator.
  function automatic longint inc_for_hz(input longint hz, input int acc_w);
    return ((hz << acc_w) + REFCLK_HZ / 2) / REFCLK_HZ;
  endfunction

endpackage

// File: rtl/clken_nco_gen_if.sv
// Configuration/enable bundle between a controller and clken_nco_gen.
// Carries sq_out only when CLKEN_NCO_SQUARE_EN is defined.
interface clken_nco_if #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 24
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [NUM_CH-1:0] ce;
  logic              locked;
`ifdef CLKEN_NCO_SQUARE_EN
  logic [NUM_CH-1:0] sq_out;
`endif

  modport master (
    output ch_en, cfg_we, cfg_ch, cfg_inc,
    input  ce, locked
`ifdef CLKEN_NCO_SQUARE_EN
    , input sq_out
`endif
  );

  modport slave (
    input  ch_en, cfg_we, cfg_ch, cfg_inc,
    output ce, locked
`ifdef CLKEN_NCO_SQUARE_EN
    , output sq_out
`endif
  );

endinterface

// File: rtl/clken_nco_gen_nco_chan.sv
// One phase-accumulator channel: registered carry becomes the ce pulse.
// With CLKEN_NCO_SQUARE_EN defined, sq_o toggles on every ce pulse.
module nco_chan #(
  parameter int ACC_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             ce_o
`ifdef CLKEN_NCO_SQUARE_EN
  , output logic           sq_o
`endif
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc_i};
    acc_d = acc_q;
    ce_d  = 1'b0;
    // A load restarts the phase and swallows any carry of this edge.
    if (load_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = sum[ACC_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

`ifdef CLKEN_NCO_SQUARE_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = sq_q;
    if (load_i)    sq_d = 1'b0;
    else if (ce_d) sq_d = ~sq_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sq_q <= 1'b0;
    else       sq_q <= sq_d;
  end

  assign sq_o = sq_q;
`endif

endmodule

// File: rtl/clken_nco_gen.sv
// NUM_CH fractional-rate clock-enable generator with runtime-programmable increments.
// Define CLKEN_NCO_SQUARE_EN to add per-channel square-wave outputs (bus.sq_out).
module clken_nco_gen
  import clken_nco_pkg::*;
#(
  parameter int                        NUM_CH   = 2,
  parameter int                        ACC_W    = ACC_W_DEF,
  parameter logic [NUM_CH*ACC_W-1:0]   INC_INIT = {INC_VDP, INC_UART},
  parameter int                        SETTLE   = 16
) (
  input  logic       refclk,
  input  logic       rst,
  clken_nco_if.slave bus
);

  localparam int SET_W = $clog2(SETTLE + 1);

  logic                wr_vld;
  logic [NUM_CH-1:0]   load;
  logic [ACC_W-1:0]    inc_q [NUM_CH];
  logic [SET_W-1:0]    settle_q, settle_d;
  logic                locked_q, locked_d;
  logic [NUM_CH-1:0]   ce_w;
`ifdef CLKEN_NCO_SQUARE_EN
  logic [NUM_CH-1:0]   sq_w;
`endif

  // Writes addressed past the last channel are dropped without side effects.
  always_comb begin
    wr_vld = bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH);
    load   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = wr_vld && (int'(bus.cfg_ch) == i);
    end
  end

  always_comb begin
    settle_d = settle_q;
    if (wr_vld)                settle_d = SET_W'(SETTLE);
    else if (settle_q != '0)   settle_d = settle_q - 1'b1;
    locked_d = !wr_vld && (settle_q <= SET_W'(1));
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      settle_q <= SET_W'(SETTLE);
      locked_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
    end else begin
      settle_q <= settle_d;
      locked_q <= locked_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) inc_q[i] <= bus.cfg_inc;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    nco_chan #(.ACC_W(ACC_W)) u_chan (
      .clk_i  (refclk),
      .rst_i  (rst),
      .en_i   (bus.ch_en[g]),
      .load_i (load[g]),
      .inc_i  (inc_q[g]),
      .ce_o   (ce_w[g])
`ifdef CLKEN_NCO_SQUARE_EN
      , .sq_o (sq_w[g])
`endif
    );
  end

  assign bus.ce     = ce_w;
  assign bus.locked = locked_q;
`ifdef CLKEN_NCO_SQUARE_EN
  assign bus.sq_out = sq_w;
`endif

endmodule
